// File: rtl/vga_sync_receiver.sv
// -----------------------------------------------------------------------------
// vga_sync_receiver
//
// Sink end of a VGA-style display timing interface. Locks onto the incoming
// hSync/vSync pattern, checks every line and frame against the configured
// timing, and re-emits each active pixel with its x/y position.
//
// Optional feature: define VGA_RX_CRC_EN to build a 16-bit per-frame pixel
// checksum on frameSum. Without it, frameSum is tied to zero.
//
// Ports:
//   clk         system clock
//   reset       synchronous, active-high reset
//   pixEn       one-clk strobe per pixel; every input is sampled only then
//   hSync       horizontal sync, active low
//   vSync       vertical sync, active low
//   rgbIn       {R,G,B}, 4 bits each
//   x, y        active pixel column / line (0 outside the active window)
//   active      x/y/pixOut qualifier
//   pixOut      rgbIn while active, else 0
//   frameStart  one-clk pulse on the first active pixel of a locked frame
//   locked      timing lock achieved
//   syncErr     one-clk pulse on a timing violation while seeking or locked
//   frameCount  locked frames seen, wraps
//   frameSum    per-frame sum of active rgbIn values (VGA_RX_CRC_EN only)
// -----------------------------------------------------------------------------
module vga_sync_receiver #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pixEn,
  input  logic        hSync,
  input  logic        vSync,
  input  logic [11:0] rgbIn,
  output logic [9:0]  x,
  output logic [8:0]  y,
  output logic        active,
  output logic [11:0] pixOut,
  output logic        frameStart,
  output logic        locked,
  output logic        syncErr,
  output logic [15:0] frameCount,
  output logic [15:0] frameSum
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST_C  = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST_C  = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_START_C = 10'(H_SYNC + H_BP);
  localparam logic [9:0] H_END_C   = 10'(H_SYNC + H_BP + H_ACTIVE - 1);
  localparam logic [9:0] V_START_C = 10'(V_SYNC + V_BP);
  localparam logic [9:0] V_END_C   = 10'(V_SYNC + V_BP + V_ACTIVE - 1);
  localparam logic [9:0] V_BLANK_C = 10'(V_SYNC + V_BP + V_ACTIVE);

  typedef enum logic [1:0] {
    ST_UNLOCKED = 2'd0,
    ST_SEEK     = 2'd1,
    ST_LOCKED   = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        hsync_prev_q, hsync_prev_d;
  logic        vsync_prev_q, vsync_prev_d;
  logic [9:0]  h_cnt_q, h_cnt_d;
  logic [9:0]  v_cnt_q, v_cnt_d;
  logic        v_arm_q, v_arm_d;

  logic [9:0]  x_q, x_d;
  logic [8:0]  y_q, y_d;
  logic        active_q, active_d;
  logic [11:0] pix_out_q, pix_out_d;
  logic        frame_start_q, frame_start_d;
  logic        locked_q, locked_d;
  logic        sync_err_q, sync_err_d;
  logic [15:0] frame_count_q, frame_count_d;

  logic        h_fall;
  logic        v_fall;
  logic        frame_evt;
  logic        h_err;
  logic        v_err;
  logic        timing_err;

  // ---------------------------------------------------------------------------
  // Sync edge detection and horizontal / vertical position counters
  // ---------------------------------------------------------------------------
  always_comb begin
    hsync_prev_d = hsync_prev_q;
    vsync_prev_d = vsync_prev_q;
    h_cnt_d      = h_cnt_q;
    v_cnt_d      = v_cnt_q;
    v_arm_d      = v_arm_q;
    h_fall       = 1'b0;
    v_fall       = 1'b0;
    frame_evt    = 1'b0;
    h_err        = 1'b0;
    v_err        = 1'b0;

    if (pixEn) begin
      h_fall       = hsync_prev_q & ~hSync;
      v_fall       = vsync_prev_q & ~vSync;
      hsync_prev_d = hSync;
      vsync_prev_d = vSync;

      // A line must end exactly at H_TOTAL-1; a missing edge also wraps.
      if (h_fall) begin
        h_cnt_d = '0;
        h_err   = (h_cnt_q != H_LAST_C);
      end else if (h_cnt_q == H_LAST_C) begin
        h_cnt_d = '0;
        h_err   = 1'b1;
      end else begin
        h_cnt_d = h_cnt_q + 10'd1;
      end

      // vSync falls somewhere in a line; it is consumed at the next line
      // start, or at this one if both edges land on the same sample.
      if (h_fall) begin
        v_arm_d = 1'b0;
        if (v_arm_q || v_fall) begin
          frame_evt = 1'b1;
          v_cnt_d   = '0;
          v_err     = (v_cnt_q != V_LAST_C);
        end else if (v_cnt_q == V_LAST_C) begin
          v_cnt_d = '0;
          v_err   = 1'b1;
        end else begin
          v_cnt_d = v_cnt_q + 10'd1;
        end
      end else if (v_fall) begin
        v_arm_d = 1'b1;
      end
    end
  end

  assign timing_err = h_err | v_err;

  // ---------------------------------------------------------------------------
  // Lock FSM: one clean frame (frame start to frame start) is needed to lock
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    sync_err_d = 1'b0;

    if (pixEn) begin
      unique case (state_q)
        ST_UNLOCKED: begin
          if (frame_evt) state_d = ST_SEEK;
        end
        ST_SEEK: begin
          if (timing_err)     state_d = ST_UNLOCKED;
          else if (frame_evt) state_d = ST_LOCKED;
        end
        ST_LOCKED: begin
          if (timing_err) state_d = ST_UNLOCKED;
        end
        default: state_d = ST_UNLOCKED;
      endcase
      // Violations while unlocked are expected noise and are not reported.
      sync_err_d = timing_err && (state_q != ST_UNLOCKED);
    end
  end

  // ---------------------------------------------------------------------------
  // Registered pixel outputs, computed from the post-update counters so each
  // output reflects the pixel sampled on the same edge.
  // ---------------------------------------------------------------------------
  always_comb begin
    x_d           = x_q;
    y_d           = y_q;
    active_d      = active_q;
    pix_out_d     = pix_out_q;
    locked_d      = locked_q;
    frame_count_d = frame_count_q;
    frame_start_d = 1'b0;

    if (pixEn) begin
      locked_d = (state_d == ST_LOCKED);
      active_d = locked_d &&
                 (h_cnt_d >= H_START_C) && (h_cnt_d <= H_END_C) &&
                 (v_cnt_d >= V_START_C) && (v_cnt_d <= V_END_C);
      if (active_d) begin
        x_d       = h_cnt_d - H_START_C;
        y_d       = 9'(v_cnt_d - V_START_C);
        pix_out_d = rgbIn;
      end else begin
        x_d       = '0;
        y_d       = '0;
        pix_out_d = '0;
      end
      frame_start_d = active_d && (h_cnt_d == H_START_C) && (v_cnt_d == V_START_C);
      if (frame_start_d) frame_count_d = frame_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_UNLOCKED;
      hsync_prev_q  <= 1'b1;
      vsync_prev_q  <= 1'b1;
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      v_arm_q       <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
      active_q      <= 1'b0;
      pix_out_q     <= '0;
      frame_start_q <= 1'b0;
      locked_q      <= 1'b0;
      sync_err_q    <= 1'b0;
      frame_count_q <= '0;
    end else begin
      state_q       <= state_d;
      hsync_prev_q  <= hsync_prev_d;
      vsync_prev_q  <= vsync_prev_d;
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      v_arm_q       <= v_arm_d;
      x_q           <= x_d;
      y_q           <= y_d;
      active_q      <= active_d;
      pix_out_q     <= pix_out_d;
      frame_start_q <= frame_start_d;
      locked_q      <= locked_d;
      sync_err_q    <= sync_err_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign x          = x_q;
  assign y          = y_q;
  assign active     = active_q;
  assign pixOut     = pix_out_q;
  assign frameStart = frame_start_q;
  assign locked     = locked_q;
  assign syncErr    = sync_err_q;
  assign frameCount = frame_count_q;

`ifdef VGA_RX_CRC_EN
  // ---------------------------------------------------------------------------
  // Per-frame checksum: restarts with the first active pixel, and the total is
  // captured when the first vertical blanking line begins.
  // ---------------------------------------------------------------------------
  logic [15:0] crc_acc_q, crc_acc_d;
  logic [15:0] frame_sum_q, frame_sum_d;

  always_comb begin
    crc_acc_d   = crc_acc_q;
    frame_sum_d = frame_sum_q;
    if (pixEn) begin
      if (frame_start_d)  crc_acc_d = {4'h0, rgbIn};
      else if (active_d)  crc_acc_d = crc_acc_q + {4'h0, rgbIn};
      if (h_fall && (v_cnt_d == V_BLANK_C)) frame_sum_d = crc_acc_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      crc_acc_q   <= '0;
      frame_sum_q <= '0;
    end else begin
      crc_acc_q   <= crc_acc_d;
      frame_sum_q <= frame_sum_d;
    end
  end

  assign frameSum = frame_sum_q;
`else
  assign frameSum = 16'h0000;
`endif

endmodule

// File: tb/tb_vga_sync_receiver.sv
// -----------------------------------------------------------------------------
// tb_vga_sync_receiver
//
// Drives a scaled-down VGA timing (25 x 23 total, 16 x 16 active) so several
// complete frames fit in a short run. The driver pushes the expected response
// of every pixel into a queue; a monitor pops and compares after each sampled
// pixEn strobe.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_vga_sync_receiver;

  localparam int HA = 16, HF = 2, HS = 4, HB = 3;
  localparam int VA = 16, VF = 2, VS = 2, VB = 3;
  localparam int HT = HA + HF + HS + HB;   // 25
  localparam int VT = VA + VF + VS + VB;   // 23
  localparam int HSTART = HS + HB;         // 7
  localparam int VSTART = VS + VB;         // 5
  localparam int VBLANK = VSTART + VA;     // 21
  localparam int NONE   = -5;

  logic        clk = 1'b0;
  logic        reset;
  logic        pixEn;
  logic        hSync;
  logic        vSync;
  logic [11:0] rgbIn;
  logic [9:0]  x;
  logic [8:0]  y;
  logic        active;
  logic [11:0] pixOut;
  logic        frameStart;
  logic        locked;
  logic        syncErr;
  logic [15:0] frameCount;
  logic [15:0] frameSum;

  always #5 clk = ~clk;

  vga_sync_receiver #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
  ) dut (
    .clk(clk), .reset(reset), .pixEn(pixEn), .hSync(hSync), .vSync(vSync),
    .rgbIn(rgbIn), .x(x), .y(y), .active(active), .pixOut(pixOut),
    .frameStart(frameStart), .locked(locked), .syncErr(syncErr),
    .frameCount(frameCount), .frameSum(frameSum)
  );

  typedef struct packed {
    logic [15:0] frm;
    logic [15:0] l;
    logic [15:0] p;
    logic [9:0]  x;
    logic [8:0]  y;
    logic        act;
    logic [11:0] pix;
    logic        fs;
    logic        lk;
    logic        err;
    logic [15:0] fc;
    logic [15:0] fsum;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e, mon_a;

  int   n_checks = 0;
  int   n_fail   = 0;
  bit   done     = 1'b0;

  int          cur_frame = 0;
  logic        exp_lk;
  logic [15:0] exp_fc;
  logic [15:0] exp_acc;
  logic [15:0] exp_sum;

  task automatic finish_test();
    if (!done) begin
      done = 1'b1;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
    end
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, got, want);
    end
  endtask

  // Monitor: every sampled pixel produces one registered response.
  always @(posedge clk) begin
    if (pixEn && !reset) begin
      #1;
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL pix_queue: got an output with no expected entry, want a queued entry");
      end else begin
        mon_e      = exp_q.pop_front();
        mon_a      = mon_e;
        mon_a.x    = x;
        mon_a.y    = y;
        mon_a.act  = active;
        mon_a.pix  = pixOut;
        mon_a.fs   = frameStart;
        mon_a.lk   = locked;
        mon_a.err  = syncErr;
        mon_a.fc   = frameCount;
        mon_a.fsum = frameSum;
        if (mon_a !== mon_e) begin
          n_fail++;
          $display("FAIL pix f%0d l%0d p%0d: got x=%0d y=%0d act=%b pix=%h fs=%b lk=%b err=%b fc=%0d sum=%h, want x=%0d y=%0d act=%b pix=%h fs=%b lk=%b err=%b fc=%0d sum=%h",
                   mon_e.frm, mon_e.l, mon_e.p,
                   mon_a.x, mon_a.y, mon_a.act, mon_a.pix, mon_a.fs, mon_a.lk, mon_a.err, mon_a.fc, mon_a.fsum,
                   mon_e.x, mon_e.y, mon_e.act, mon_e.pix, mon_e.fs, mon_e.lk, mon_e.err, mon_e.fc, mon_e.fsum);
        end
      end
      if (n_fail >= 30) finish_test();
    end
  end

  // Watchdog: the whole run is about 25k clocks.
  initial begin
    #2_000_000;
    n_checks++;
    n_fail++;
    $display("FAIL watchdog: got simulation still running at %0t, want finished", $time);
    finish_test();
  end

  task automatic drive_pixel(input logic hs, input logic vs, input logic [11:0] rgb, input exp_t e);
    @(negedge clk);
    pixEn = 1'b1;
    hSync = hs;
    vSync = vs;
    rgbIn = rgb;
    exp_q.push_back(e);
    @(negedge clk);
    pixEn = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  // lk: expected lock for the whole frame from its first sample.
  // short_line: line emitted one pixel short (error on the next line start).
  // hold_line: pixEn held off for 100 clks after an active pixel of this line.
  // stop_line: abort mid-line inside this line (for the reset test).
  task automatic send_frame(input logic lk, input int short_line, input int hold_line,
                            input int stop_line, input bit flat);
    exp_t        e;
    int          plen;
    int          ax, ay;
    logic [11:0] rgb;
    bit          aborted;
    aborted = 1'b0;
    cur_frame++;
    for (int l = 0; l < VT; l++) begin
      plen = (l == short_line) ? HT - 1 : HT;
      for (int p = 0; p < plen; p++) begin
        if (l == stop_line && p == HSTART + 3) begin
          aborted = 1'b1;
          break;
        end
        e = '0;
        if (l == 0 && p == 0) exp_lk = lk;
        e.err = (l == short_line + 1) && (p == 0);
        if (e.err) exp_lk = 1'b0;
        ax  = p - HSTART;
        ay  = l - VSTART;
        rgb = flat ? 12'h001 : {ax[3:0], ay[3:0], 4'hA};
        e.act = exp_lk && (p >= HSTART) && (p < HSTART + HA) && (l >= VSTART) && (l < VSTART + VA);
        if (e.act) begin
          e.x   = ax[9:0];
          e.y   = ay[8:0];
          e.pix = rgb;
        end
        e.fs = e.act && (ax == 0) && (ay == 0);
        if (e.fs) exp_fc = exp_fc + 16'd1;
`ifdef VGA_RX_CRC_EN
        if (e.fs)       exp_acc = {4'h0, rgb};
        else if (e.act) exp_acc = exp_acc + {4'h0, rgb};
        if (l == VBLANK && p == 0) exp_sum = exp_acc;
`endif
        e.frm  = 16'(cur_frame);
        e.l    = 16'(l);
        e.p    = 16'(p);
        e.lk   = exp_lk;
        e.fc   = exp_fc;
        e.fsum = exp_sum;
        drive_pixel((p < HS) ? 1'b0 : 1'b1, (l < VS) ? 1'b0 : 1'b1, rgb, e);
        if (l == hold_line && p == HSTART + 5) begin
          repeat (100) @(negedge clk);
          check("hold_x", 32'(x), 32'(e.x));
          check("hold_y", 32'(y), 32'(e.y));
          check("hold_pixOut", 32'(pixOut), 32'(e.pix));
          check("hold_syncErr", 32'(syncErr), 32'd0);
          check("hold_frameStart", 32'(frameStart), 32'd0);
          check("hold_locked", 32'(locked), 32'(e.lk));
        end
      end
      if (aborted) break;
    end
    $display("frame %0d sent: lock_exp=%0b short_line=%0d hold_line=%0d stop_line=%0d frameCount_exp=%0d",
             cur_frame, lk, short_line, hold_line, stop_line, exp_fc);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_x"}, 32'(x), 32'd0);
    check({tag, "_y"}, 32'(y), 32'd0);
    check({tag, "_active"}, 32'(active), 32'd0);
    check({tag, "_pixOut"}, 32'(pixOut), 32'd0);
    check({tag, "_frameStart"}, 32'(frameStart), 32'd0);
    check({tag, "_locked"}, 32'(locked), 32'd0);
    check({tag, "_syncErr"}, 32'(syncErr), 32'd0);
    check({tag, "_frameCount"}, 32'(frameCount), 32'd0);
    check({tag, "_frameSum"}, 32'(frameSum), 32'd0);
  endtask

  initial begin
    reset   = 1'b1;
    pixEn   = 1'b0;
    hSync   = 1'b1;
    vSync   = 1'b1;
    rgbIn   = '0;
    exp_lk  = 1'b0;
    exp_fc  = '0;
    exp_acc = '0;
    exp_sum = '0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    reset = 1'b0;

    // Acquire lock: seek on frame 1, lock at frame 2 start.
    send_frame(1'b0, NONE, NONE, NONE, 1'b0);
    send_frame(1'b1, NONE, NONE, NONE, 1'b0);
    check("frameCount_after_f2", 32'(frameCount), 32'd1);
    send_frame(1'b1, NONE, NONE, NONE, 1'b0);
    check("frameCount_after_f3", 32'(frameCount), 32'd2);

    // Short line drops lock; two frame starts are needed to relock.
    send_frame(1'b1, 5, NONE, NONE, 1'b0);
    check("locked_after_short_line", 32'(locked), 32'd0);
    send_frame(1'b0, NONE, NONE, NONE, 1'b0);
    send_frame(1'b1, NONE, 8, NONE, 1'b0);
    check("relocked", 32'(locked), 32'd1);

    // Reset mid-frame during an active pixel.
    send_frame(1'b1, NONE, NONE, 10, 1'b0);
    check("pre_reset_locked", 32'(locked), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midreset_locked", 32'(locked), 32'd0);
    check("midreset_frameCount", 32'(frameCount), 32'd0);
    check("midreset_x", 32'(x), 32'd0);
    check("midreset_y", 32'(y), 32'd0);
    check("midreset_active", 32'(active), 32'd0);
    exp_lk  = 1'b0;
    exp_fc  = '0;
    exp_acc = '0;
    exp_sum = '0;

    // Relock from scratch, then a flat-colour frame for the checksum.
    send_frame(1'b0, NONE, NONE, NONE, 1'b0);
    send_frame(1'b1, NONE, NONE, NONE, 1'b0);
    check("frameCount_after_relock", 32'(frameCount), 32'd1);
    send_frame(1'b1, NONE, NONE, NONE, 1'b1);
`ifdef VGA_RX_CRC_EN
    check("frameSum_flat", 32'(frameSum), 32'h0100);
`else
    check("frameSum_flat", 32'(frameSum), 32'h0000);
`endif
    check("frameCount_final", 32'(frameCount), 32'd2);

    repeat (4) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    finish_test();
  end

endmodule
